// File: rtl/bram_4096x4_stream_reader_if.sv
// Port bundle for the BRAM stream reader: control, one BRAM port and the output stream.
// Optional OUT_LAST signal is present when BRAM_STREAM_READER_LAST_EN is defined.
// Handshakes: a control request is taken when start=1 and busy=0; a stream beat
// transfers on a rising clk edge where out_valid=1 and out_ready=1, and out_data/out_valid
// hold steady while out_valid=1 and out_ready=0.
interface bram_4096x4_stream_reader_if #(
    parameter int ABITS = 12,
    parameter int DBITS = 4
);
    logic             start;
    logic [ABITS-1:0] base;
    logic [ABITS:0]   len;
    logic             busy;
    logic             done;
    logic [ABITS-1:0] a;
    logic             ce;
    logic             we;
    logic [DBITS-1:0] q;
    logic [DBITS-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef BRAM_STREAM_READER_LAST_EN
    logic             out_last;
`endif

    // master: the reader itself; slave: controller, BRAM and stream sink around it
    modport master (
        input  start, base, len, q, out_ready,
        output busy, done, a, ce, we, out_data, out_valid
`ifdef BRAM_STREAM_READER_LAST_EN
        , output out_last
`endif
    );

    modport slave (
        output start, base, len, q, out_ready,
        input  busy, done, a, ce, we, out_data, out_valid
`ifdef BRAM_STREAM_READER_LAST_EN
        , input out_last
`endif
    );
endinterface

// File: rtl/bram_4096x4_stream_reader.sv
// Reads a wrapping address range from one BRAM port and streams the words out through a
// 3-entry FIFO. Define BRAM_STREAM_READER_LAST_EN to add the out_last end-of-transfer flag.
module bram_4096x4_stream_reader #(
    parameter int ABITS = 12,
    parameter int DBITS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    bram_4096x4_stream_reader_if.master       bus,
    output logic [1:0]                        dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [ABITS-1:0] addr;
    logic [ABITS:0]   issue_cnt;
    logic [ABITS:0]   beat_cnt;
    logic             inflight;
    logic             done_r;

    logic [DBITS-1:0] fifo_d   [3];
    logic [DBITS-1:0] fifo_d_n [3];
    logic [1:0]       fifo_cnt, fifo_cnt_n;
    logic [1:0]       wr_idx;

    logic             accept, load, issue, push, pop, last_beat, last_issue;
    logic [2:0]       occupancy;

    // Issue is gated only by registered state, keeping out_ready off the ce/a path.
    assign occupancy  = {1'b0, fifo_cnt} + {2'b00, inflight};
    assign issue      = (state == READ) && (issue_cnt != '0) && (occupancy < 3'd3);
    assign last_issue = issue && (issue_cnt == (ABITS+1)'(1));
    assign accept     = (state == IDLE) && bus.start;
    assign load       = accept && (bus.len != '0);
    assign push       = inflight;
    assign pop        = (fifo_cnt != 2'd0) && bus.out_ready;
    assign last_beat  = pop && (beat_cnt == (ABITS+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        bus.busy      = 1'b0;
        bus.ce        = 1'b0;
        bus.we        = 1'b0;
        bus.a         = addr;
        bus.done      = done_r;
        bus.out_valid = (fifo_cnt != 2'd0);
        bus.out_data  = fifo_d[0];
        dbg_state     = state;
        unique case (state)
            IDLE: begin
                if (load) state_n = READ;
            end
            READ: begin
                bus.busy = 1'b1;
                bus.ce   = issue;
                if (last_issue) state_n = DRAIN;
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (last_beat) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            // A zero-length request completes on the accepting edge with no reads.
            done_r   <= (accept && (bus.len == '0)) || ((state == DRAIN) && last_beat);
            inflight <= issue;
            if (load) begin
                addr      <= bus.base;
                issue_cnt <= bus.len;
                beat_cnt  <= bus.len;
            end else begin
                if (issue) begin
                    addr      <= addr + 1'b1;
                    issue_cnt <= issue_cnt - 1'b1;
                end
                if (pop && (beat_cnt != '0)) begin
                    beat_cnt <= beat_cnt - 1'b1;
                end
            end
        end
    end

    // Shift FIFO: entry 0 is the head; a pop shifts down before the push slot is chosen.
    always_comb begin
        fifo_d_n = fifo_d;
        wr_idx   = fifo_cnt;
        if (pop) begin
            fifo_d_n[0] = fifo_d[1];
            fifo_d_n[1] = fifo_d[2];
            wr_idx      = fifo_cnt - 2'd1;
        end
        if (push) begin
            for (int i = 0; i < 3; i++) begin
                if (wr_idx == 2'(i)) fifo_d_n[i] = bus.q;
            end
        end
        fifo_cnt_n = fifo_cnt + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_cnt <= 2'd0;
            for (int i = 0; i < 3; i++) fifo_d[i] <= '0;
        end else begin
            fifo_cnt <= fifo_cnt_n;
            fifo_d   <= fifo_d_n;
        end
    end

`ifdef BRAM_STREAM_READER_LAST_EN
    logic inflight_last;
    logic fifo_t   [3];
    logic fifo_t_n [3];

    always_comb begin
        fifo_t_n = fifo_t;
        if (pop) begin
            fifo_t_n[0] = fifo_t[1];
            fifo_t_n[1] = fifo_t[2];
        end
        if (push) begin
            for (int i = 0; i < 3; i++) begin
                if (wr_idx == 2'(i)) fifo_t_n[i] = inflight_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_last <= 1'b0;
            for (int i = 0; i < 3; i++) fifo_t[i] <= 1'b0;
        end else begin
            inflight_last <= last_issue;
            fifo_t        <= fifo_t_n;
        end
    end

    assign bus.out_last = (fifo_cnt != 2'd0) && fifo_t[0];
`endif
endmodule

// File: tb/tb_bram_4096x4_stream_reader.sv
// Bench for bram_4096x4_stream_reader: BRAM model, directed and randomized transfers,
// scoreboard of expected words and addresses derived from base/len arithmetic.
module tb_bram_4096x4_stream_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    bram_4096x4_stream_reader_if #(.ABITS(12), .DBITS(4)) bus ();

    bram_4096x4_stream_reader #(.ABITS(12), .DBITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency
    logic [3:0] mem [4096];
    always @(posedge clk) begin
        if (bus.ce) bus.q <= mem[bus.a];
    end

    // Reference model state
    logic [3:0] exp_q [$];
    int         cur_base   = 0;
    int         issued     = 0;
    int         popped     = 0;
    int         done_total = 0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_data  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic pat(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k % 4) == 0) || ((k % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Scoreboard / protocol monitor, sampling between active edges
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.ce) begin
                chk("ce_addr", 32'(bus.a), 32'((cur_base + issued) % 4096));
                chk("ce_occupancy", 32'((issued - popped) < 3), 32'd1);
                chk("we_low", 32'(bus.we), 32'd0);
                issued++;
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_data", 32'(bus.out_data), 32'(prev_data));
            end
`ifdef BRAM_STREAM_READER_LAST_EN
            if (bus.out_valid) chk("out_last", 32'(bus.out_last), 32'(exp_q.size() == 1));
`endif
            if (bus.out_valid && bus.out_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("beat_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                popped++;
            end
            if (bus.done) done_total++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic load_model(input int b, input int n);
        cur_base = b;
        issued   = 0;
        popped   = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % 4096]);
    endtask

    // Runs one transfer; entered and left just after a rising edge.
    task automatic run_xfer(input int b, input int n, input int mode, input bit inject);
        int first_k = -1;
        int done_k  = -1;
        int done_before;
        load_model(b, n);
        done_before   = done_total;
        bus.start     = 1'b1;
        bus.base      = 12'(b);
        bus.len       = 13'(n);
        bus.out_ready = pat(mode, 0);
        @(posedge clk); #1;
        bus.start     = 1'b0;
        for (int k = 0; k < 4 * n + 50; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_after_start", 32'(bus.busy), 32'(n != 0));
            if (n == 0) chk("busy_len0", 32'(bus.busy), 32'd0);
            if (first_k < 0 && bus.out_valid) first_k = k;
            if (bus.done && done_k < 0) done_k = k;
            @(posedge clk); #1;
            bus.out_ready = pat(mode, k + 1);
            if (inject && k == 1) begin
                bus.start = 1'b1;
                bus.base  = 12'h0AA;
                bus.len   = 13'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (done_k >= 0) break;
        end
        bus.start = 1'b0;
        chk("done_seen", 32'(done_k >= 0), 32'd1);
        if (mode == 0) begin
            chk("done_latency", 32'(done_k), 32'((n == 0) ? 0 : n + 2));
            if (n != 0) chk("first_beat_latency", 32'(first_k), 32'd2);
        end
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 32'(done_total - done_before), 32'd1);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        chk("reads_issued", 32'(issued), 32'(n));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_a"}, 32'(bus.a), 32'd0);
        chk({tag, "_ce"}, 32'(bus.ce), 32'd0);
        chk({tag, "_we"}, 32'(bus.we), 32'd0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
`ifdef BRAM_STREAM_READER_LAST_EN
        chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start     = 1'b0;
        bus.base      = '0;
        bus.len       = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 4'(i);

        // Clock/reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("reset");
        chk("reset_state", 32'(dbg_state), 32'd0);

        // Directed transfers
        run_xfer(12'h010, 16, 0, 1'b0);
        run_xfer(12'hFFE, 4, 0, 1'b0);
        run_xfer(12'h020, 8, 1, 1'b0);
        run_xfer(12'h030, 0, 0, 1'b0);
        run_xfer(12'h040, 10, 0, 1'b1);
        run_xfer(12'h050, 3, 0, 1'b0);
        run_xfer(12'h060, 1, 0, 1'b0);

        // Reset in the middle of a transfer, then a fresh short one
        load_model(12'h200, 20);
        bus.start     = 1'b1;
        bus.base      = 12'h200;
        bus.len       = 13'd20;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (popped >= 3) break;
            @(posedge clk); #1;
        end
        chk("beats_before_reset", 32'(popped >= 3), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("midreset");
        run_xfer(12'h100, 2, 0, 1'b0);

        // Full-range transfer wrapping the whole address space
        run_xfer(12'h7FF, 4096, 0, 1'b0);

        // Randomized content, ranges and backpressure
        for (int i = 0; i < 4096; i++) mem[i] = 4'($urandom);
        for (int t = 0; t < 20; t++) begin
            run_xfer(int'($urandom_range(0, 4095)), int'($urandom_range(1, 40)),
                     int'($urandom_range(0, 2)), 1'b0);
        end
        run_xfer(12'hFFD, 7, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
